// File: rtl/arb_pkg.sv
// Shared types for the IF/D memory-port arbiter: FSM states, transaction owner
// and the address bit that picks the 32-bit fetch word out of a 64-bit line.
package arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_D
  } arb_owner_e;

  localparam int IF_WORD_SEL_BIT = 2;
  localparam int IF_W            = 32;

endpackage

// File: rtl/arb_prio.sv
// Winner selection between fetch and data requesters. Data wins by default;
// with ARB_FAIR_EN a starve counter lets fetch win after STARVE_MAX losses.
import arb_pkg::*;

module arb_prio #(
  parameter int STARVE_MAX = 4
) (
`ifdef ARB_FAIR_EN
  input  logic clk,
  input  logic reset,
`endif
  input  logic idle,
  input  logic if_req,
  input  logic d_req,
  output logic if_gnt,
  output logic d_gnt
);

  if (STARVE_MAX < 1 || STARVE_MAX > 7) begin : g_bad_starve
    $error("STARVE_MAX must fit the 3-bit starve counter (1..7)");
  end

`ifdef ARB_FAIR_EN
  logic [2:0] starve_q, starve_d;
  logic       if_first;

  assign if_first = (starve_q == 3'(STARVE_MAX));

  always_comb begin
    if_gnt   = idle & if_req & (~d_req | if_first);
    d_gnt    = idle & d_req & ~(if_req & if_first);
    starve_d = starve_q;
    if (if_gnt)              starve_d = '0;
    else if (d_gnt & if_req) starve_d = starve_q + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`else
  always_comb begin
    d_gnt  = idle & d_req;
    if_gnt = idle & if_req & ~d_req;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read 64-bit memory between fetch and data ports, one
// transaction at a time. Optional fetch fairness is enabled by ARB_FAIR_EN.
import arb_pkg::*;

module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [IF_W-1:0]   if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  if (RD_LAT < 1) begin : g_bad_lat
    $error("RD_LAT must be at least 1");
  end
  if (DATA_W < 2 * IF_W) begin : g_bad_dw
    $error("DATA_W must hold two fetch words");
  end

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              mem_wr_q, mem_wr_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [IF_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
`ifdef ARB_FAIR_EN
    .clk    (clk),
    .reset  (reset),
`endif
    .idle   (state_q == ST_IDLE),
    .if_req (if_req),
    .d_req  (d_req),
    .if_gnt (if_gnt),
    .d_gnt  (d_gnt)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    lat_d       = lat_q;
    mem_wr_d    = 1'b0;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (d_gnt) begin
          addr_d   = d_addr;
          wdata_d  = d_wdata;
          we_d     = d_we;
          owner_d  = OWN_D;
          mem_wr_d = d_we;
          state_d  = ST_ACCESS;
        end else if (if_gnt) begin
          addr_d  = if_addr;
          wdata_d = '0;
          we_d    = 1'b0;
          owner_d = OWN_IF;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        lat_d   = LAT_W'(RD_LAT - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // mem_rdata is valid in the last wait cycle; capture it on the way out
        if (lat_q == '0) begin
          state_d = ST_RESP;
          if (owner_q == OWN_IF) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = addr_q[IF_WORD_SEL_BIT] ? mem_rdata[2*IF_W-1:IF_W]
                                                  : mem_rdata[IF_W-1:0];
          end else if (owner_q == OWN_D) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = we_q ? '0 : mem_rdata;
          end
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_NONE;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      lat_q       <= '0;
      mem_wr_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      lat_q       <= lat_d;
      mem_wr_q    <= mem_wr_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_raddr = addr_q;
  assign mem_waddr = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wr    = mem_wr_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: RD_LAT=1 main instance plus an
// RD_LAT=3 instance for latency/busy-blocking checks.
module tb_mem_port_arbiter;

  localparam int RD_LAT = 1;
`ifdef ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main DUT (RD_LAT=1)
  logic        if_req, if_gnt, if_rvalid;
  logic [63:0] if_addr;
  logic [31:0] if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [63:0] d_addr, d_wdata, d_rdata;
  logic [63:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
  logic        mem_wr, busy;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .RD_LAT(RD_LAT), .STARVE_MAX(4)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  logic [63:0] mem_m [0:255];
  logic [63:0] exp_mem [0:255];
  logic [63:0] rd_pipe;
  always @(posedge clk) begin
    if (mem_wr) mem_m[mem_waddr[10:3]] <= mem_wdata;
    rd_pipe <= mem_m[mem_raddr[10:3]];
  end
  assign mem_rdata = rd_pipe;

  // second DUT (RD_LAT=3)
  logic        if3_req, if3_gnt, if3_rvalid;
  logic [63:0] if3_addr;
  logic [31:0] if3_rdata;
  logic        d3_req, d3_we, d3_gnt, d3_rvalid;
  logic [63:0] d3_addr, d3_wdata, d3_rdata;
  logic [63:0] m3_raddr, m3_waddr, m3_wdata, m3_rdata;
  logic        m3_wr, busy3;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .RD_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk(clk), .reset(reset),
    .if_req(if3_req), .if_addr(if3_addr), .if_gnt(if3_gnt), .if_rvalid(if3_rvalid), .if_rdata(if3_rdata),
    .d_req(d3_req), .d_we(d3_we), .d_addr(d3_addr), .d_wdata(d3_wdata),
    .d_gnt(d3_gnt), .d_rvalid(d3_rvalid), .d_rdata(d3_rdata),
    .mem_raddr(m3_raddr), .mem_waddr(m3_waddr), .mem_wdata(m3_wdata), .mem_wr(m3_wr),
    .mem_rdata(m3_rdata), .busy(busy3)
  );

  logic [63:0] mem3 [0:255];
  logic [63:0] p3 [0:2];
  always @(posedge clk) begin
    if (m3_wr) mem3[m3_waddr[10:3]] <= m3_wdata;
    p3[0] <= mem3[m3_raddr[10:3]];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign m3_rdata = p3[2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h @cyc %0d", tag, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit          is_if;
    logic [63:0] data;
    int          t;
  } exp_t;
  exp_t sbq[$];
  exp_t e;

  int wr_cyc = -1;
  int wr_cnt = 0;

  always @(negedge clk) begin
    #2;
    chk("one_gnt", 64'(if_gnt & d_gnt), 64'd0);
    if (mem_wr) begin
      wr_cyc = cyc;
      wr_cnt++;
    end
    if (if_rvalid || d_rvalid) begin
      if (sbq.size() == 0) chk("spurious_rvalid", 64'({if_rvalid, d_rvalid}), 64'd0);
      else begin
        e = sbq.pop_front();
        chk("rsp_owner", 64'({if_rvalid, d_rvalid}), e.is_if ? 64'd2 : 64'd1);
        chk("rsp_data", e.is_if ? 64'(if_rdata) : d_rdata, e.data);
        chk("rsp_cycle", 64'(cyc), 64'(e.t));
      end
    end
  end

  task automatic push_if(input logic [63:0] addr, input int t);
    exp_t x;
    logic [63:0] w;
    w = exp_mem[addr[10:3]];
    x.is_if = 1'b1;
    x.data  = addr[2] ? {32'd0, w[63:32]} : {32'd0, w[31:0]};
    x.t     = t + 2 + RD_LAT;
    sbq.push_back(x);
  endtask

  task automatic push_d(input logic we, input logic [63:0] addr, input logic [63:0] wdata, input int t);
    exp_t x;
    x.is_if = 1'b0;
    x.data  = we ? 64'd0 : exp_mem[addr[10:3]];
    x.t     = t + 2 + RD_LAT;
    sbq.push_back(x);
    if (we) exp_mem[addr[10:3]] = wdata;
  endtask

  task automatic if_txn(input logic [63:0] addr, output int t, output int n);
    @(negedge clk);
    if_req = 1'b1; if_addr = addr;
    n = 0; #1;
    while (!if_gnt && n < 100) begin @(negedge clk); #1; n++; end
    t = cyc;
    if (!if_gnt) chk("if_gnt_timeout", 64'd0, 64'd1);
    else push_if(addr, t);
    @(posedge clk); #1 if_req = 1'b0;
  endtask

  task automatic d_txn(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                       output int t, output int n);
    @(negedge clk);
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    n = 0; #1;
    while (!d_gnt && n < 100) begin @(negedge clk); #1; n++; end
    t = cyc;
    if (!d_gnt) chk("d_gnt_timeout", 64'd0, 64'd1);
    else push_d(we, addr, wdata, t);
    @(posedge clk); #1 d_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || sbq.size() != 0) && n < 100) begin @(negedge clk); n++; end
    if (busy || sbq.size() != 0) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    int t, n, ifs, grants, wb;
    bit g_if;
    for (int i = 0; i < 256; i++) begin
      mem_m[i] = 64'h0; exp_mem[i] = 64'h0; mem3[i] = 64'h0;
    end
    mem_m[8'h20] = 64'hAAAA_BBBB_1111_2222; exp_mem[8'h20] = 64'hAAAA_BBBB_1111_2222;
    mem3[8'h01]  = 64'h0123_4567_89AB_CDEF;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    if3_req = 0; if3_addr = 0; d3_req = 0; d3_we = 0; d3_addr = 0; d3_wdata = 0;

    // reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mem_wr", 64'(mem_wr), 64'd0);
    chk("rst_raddr", mem_raddr, 64'd0);
    chk("rst_rvalid", 64'({if_rvalid, d_rvalid}), 64'd0);
    reset = 1'b0;

    // IF read, upper word
    if_txn(64'h104, t, n);
    chk("if_gnt_imm", 64'(n), 64'd0);
    wait_idle();

    // store then load
    wb = wr_cnt;
    d_txn(1'b1, 64'h40, 64'hDEAD_BEEF_CAFE_F00D, t, n);
    wait_idle();
    chk("wr_cycle", 64'(wr_cyc), 64'(t + 1));
    chk("wr_once", 64'(wr_cnt - wb), 64'd1);
    d_txn(1'b0, 64'h40, 64'h0, t, n);
    wait_idle();

    // simultaneous requests: D first, IF at next idle
    @(negedge clk);
    if_req = 1'b1; if_addr = 64'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h100;
    #1;
    chk("sim_d_gnt", 64'(d_gnt), 64'd1);
    chk("sim_if_gnt", 64'(if_gnt), 64'd0);
    t = cyc;
    if (d_gnt) push_d(1'b0, 64'h100, 64'h0, t);
    @(posedge clk); #1 d_req = 1'b0;
    n = 0;
    @(negedge clk); #1;
    while (!if_gnt && n < 50) begin @(negedge clk); #1; n++; end
    chk("sim_if_gnt_cycle", 64'(cyc), 64'(t + 3 + RD_LAT));
    if (if_gnt) push_if(64'h100, cyc);
    @(posedge clk); #1 if_req = 1'b0;
    wait_idle();

    // reset in the middle of a store
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h80; d_wdata = 64'h5555_6666_7777_8888;
    #1 chk("rst_mid_gnt", 64'(d_gnt), 64'd1);
    @(posedge clk); #1;
    d_req = 1'b0;
    chk("rst_mid_wr_t1", 64'(mem_wr), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_wr", 64'(mem_wr), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_rvalid", 64'({if_rvalid, d_rvalid}), 64'd0);
    chk("rst_mid_drdata", d_rdata, 64'd0);
    chk("rst_mid_ifrdata", 64'(if_rdata), 64'd0);
    chk("rst_mid_wdata", mem_wdata, 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (6) @(posedge clk);

    // both requests held high continuously
    @(negedge clk);
    if_req = 1'b1; if_addr = 64'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h100;
    grants = 0; ifs = 0; n = 0;
    #1;
    while (grants < 10 && n < 200) begin
      if (if_gnt || d_gnt) begin
        g_if = if_gnt;
        chk("fair_seq", 64'(g_if), 64'(FAIR && (grants % 5 == 4)));
        if (g_if) begin push_if(64'h100, cyc); ifs++; end
        else push_d(1'b0, 64'h100, 64'h0, cyc);
        grants++;
      end
      if (grants < 10) begin @(negedge clk); #1; n++; end
    end
    chk("fair_grants", 64'(grants), 64'd10);
    chk("fair_if_count", 64'(ifs), FAIR ? 64'd2 : 64'd0);
    @(posedge clk); #1 if_req = 1'b0; d_req = 1'b0;
    wait_idle();

    // RD_LAT=3 instance: response timing and blocking while busy
    @(negedge clk);
    d3_req = 1'b1; d3_we = 1'b0; d3_addr = 64'h8;
    #1 chk("d3_gnt", 64'(d3_gnt), 64'd1);
    t = cyc;
    @(posedge clk); #1;
    d3_req = 1'b0; if3_req = 1'b1; if3_addr = 64'h0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk); #1;
      chk("d3_rvalid", 64'(d3_rvalid), 64'(cyc == t + 5));
      if (cyc == t + 5) chk("d3_rdata", d3_rdata, 64'h0123_4567_89AB_CDEF);
      chk("if3_gnt_wait", 64'(if3_gnt), 64'(cyc == t + 6));
    end
    @(posedge clk); #1 if3_req = 1'b0;
    repeat (8) @(posedge clk);

    wait_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
